// File: rtl/sha_stream_pkg.sv
// Shared types and helpers for the Keccak digest output path.
// Holds the state/lane types, digest-length encoding and word-count helper.
package sha_stream_pkg;

  typedef logic [63:0] lane_t;
  typedef logic [4:0][4:0][63:0] keccak_state_t;

  typedef enum logic [1:0] {
    D224 = 2'd0,
    D256 = 2'd1,
    D384 = 2'd2,
    D512 = 2'd3
  } digest_mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } stream_state_e;

  localparam int CAPTURE_LANES = 8;
  localparam int CAPTURE_BITS  = 64 * CAPTURE_LANES;
  localparam int CNT_W         = 6;

  // Number of stream words in a digest of the given mode at the given width.
  function automatic logic [6:0] digest_words(input logic [1:0] mode, input int width);
    int bits;
    case (digest_mode_e'(mode))
      D224:    bits = 224;
      D256:    bits = 256;
      D384:    bits = 384;
      default: bits = 512;
    endcase
    return 7'(bits / width);
  endfunction

  // Flattens lanes 0..7 (lane L = 5*y + x) little-endian, lane 0 in the low bits.
  function automatic logic [CAPTURE_BITS-1:0] capture_lanes(input keccak_state_t s);
    logic [CAPTURE_BITS-1:0] r;
    r = '0;
    for (int l = 0; l < CAPTURE_LANES; l++) begin
      r[64*l +: 64] = s[l/5][l%5];
    end
    return r;
  endfunction

endpackage

// File: rtl/digest_word_sel.sv
// Combinational pick of stream word k from the captured 512-bit digest prefix.
// Word k lives in lane k/(64/DATA_WIDTH) at offset DATA_WIDTH*(k mod words-per-lane).
module digest_word_sel
  import sha_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [CAPTURE_BITS-1:0] capture,
  input  logic [CNT_W-1:0]        word_idx,
  output logic [DATA_WIDTH-1:0]   word
);

  localparam int WORDS_PER_LANE = 64 / DATA_WIDTH;
  localparam int OFF_W          = $clog2(WORDS_PER_LANE);

  lane_t            lanes [CAPTURE_LANES];
  logic [2:0]       lane_idx;
  logic [OFF_W-1:0] word_off;
  logic [5:0]       bit_off;

  always_comb begin
    for (int l = 0; l < CAPTURE_LANES; l++) begin
      lanes[l] = capture[64*l +: 64];
    end
  end

  always_comb begin
    lane_idx = 3'(word_idx >> OFF_W);
    word_off = word_idx[OFF_W-1:0];
    bit_off  = 6'(DATA_WIDTH) * 6'(word_off);
    word     = lanes[lane_idx][bit_off +: DATA_WIDTH];
  end

endmodule

// File: rtl/keccak_digest_streamer.sv
// Serialises the leading digest bits of a finished Keccak state onto an
// AXI4-Stream master, one DATA_WIDTH word per beat, TLAST on the final word.
module keccak_digest_streamer
  import sha_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2,
  parameter int USER_WIDTH = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  keccak_state_t           state_in,
  input  logic                    state_valid,
  output logic                    state_ready,
  input  logic [1:0]              mode,
  input  logic [ID_WIDTH-1:0]     id_in,
  input  logic [USER_WIDTH-1:0]   user_in,
  output logic [DATA_WIDTH-1:0]   TDATA,
  output logic                    TVALID,
  input  logic                    TREADY,
  output logic                    TLAST,
  output logic [DATA_WIDTH/8-1:0] TKEEP,
  output logic [ID_WIDTH-1:0]     TID,
  output logic [USER_WIDTH-1:0]   TUSER,
  output logic                    digest_done,
  output stream_state_e           fsm_state
);

  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_width
    $error("keccak_digest_streamer: DATA_WIDTH must be 8, 16 or 32");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // state_valid/state_ready: a state is captured only in IDLE (state_ready=1).
  // TVALID/TREADY: TVALID is decoded from the FSM alone, and once raised the
  // beat (TDATA/TLAST/TID/TUSER/TKEEP) is held until TREADY accepts it.

  stream_state_e           state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        last_idx_q, last_idx_d;
  logic [CAPTURE_BITS-1:0] capture_q, capture_d;
  logic [ID_WIDTH-1:0]     tid_q, tid_d;
  logic [USER_WIDTH-1:0]   tuser_q, tuser_d;
  logic                    is_last;
  logic [DATA_WIDTH-1:0]   word;
  logic                    unused_lanes;

  // Only lanes 0..7 carry digest bits; the rest of the state is dropped.
  assign unused_lanes = ^{state_in[4], state_in[3], state_in[2], state_in[1][4:3]};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_idx_q <= '0;
      capture_q  <= '0;
      tid_q      <= '0;
      tuser_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      capture_q  <= capture_d;
      tid_q      <= tid_d;
      tuser_q    <= tuser_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_idx_d  = last_idx_q;
    capture_d   = capture_q;
    tid_d       = tid_q;
    tuser_d     = tuser_q;
    state_ready = 1'b0;
    TVALID      = 1'b0;
    TLAST       = 1'b0;
    digest_done = 1'b0;
    is_last     = (cnt_q == last_idx_q);

    case (state_q)
      S_IDLE: begin
        state_ready = 1'b1;
        if (state_valid) begin
          capture_d  = capture_lanes(state_in);
          // Store N-1 so the 6-bit counter covers N=64 without wrapping.
          last_idx_d = CNT_W'(digest_words(mode, DATA_WIDTH) - 7'd1);
          tid_d      = id_in;
          tuser_d    = user_in;
          cnt_d      = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        TVALID = 1'b1;
        TLAST  = is_last;
        if (TREADY) begin
          if (is_last) begin
            digest_done = 1'b1;
            cnt_d       = '0;
            state_d     = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  digest_word_sel #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_sel (
    .capture  (capture_q),
    .word_idx (cnt_q),
    .word     (word)
  );

  assign TDATA     = word;
  assign TKEEP     = '1;
  assign TID       = tid_q;
  assign TUSER     = tuser_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_keccak_digest_streamer.sv
// Bench for keccak_digest_streamer at DATA_WIDTH 16 and 32: directed digests,
// expected beats queued at issue time and checked by per-instance monitors.
module tb_keccak_digest_streamer;
  import sha_stream_pkg::*;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [63:0] tb_lanes [25];

  // DATA_WIDTH=16 instance
  keccak_state_t st16;
  logic sv16 = 1'b0, rdy16;
  logic [1:0] mode16 = 2'd0, id16 = 2'd0;
  logic [3:0] user16 = 4'd0;
  logic [15:0] tdata16;
  logic tvalid16, tready16 = 1'b1, tlast16, done16;
  logic [1:0] tkeep16, tid16;
  logic [3:0] tuser16;
  stream_state_e fsm16;

  // DATA_WIDTH=32 instance
  keccak_state_t st32;
  logic sv32 = 1'b0, rdy32;
  logic [1:0] mode32 = 2'd0, id32 = 2'd0;
  logic [3:0] user32 = 4'd0;
  logic [31:0] tdata32;
  logic tvalid32, tready32 = 1'b1, tlast32, done32;
  logic [3:0] tkeep32;
  logic [1:0] tid32;
  logic [3:0] tuser32;
  stream_state_e fsm32;

  keccak_digest_streamer #(.DATA_WIDTH(16), .ID_WIDTH(2), .USER_WIDTH(4)) dut16 (
    .ACLK(ACLK), .ARESET(ARESET), .state_in(st16), .state_valid(sv16),
    .state_ready(rdy16), .mode(mode16), .id_in(id16), .user_in(user16),
    .TDATA(tdata16), .TVALID(tvalid16), .TREADY(tready16), .TLAST(tlast16),
    .TKEEP(tkeep16), .TID(tid16), .TUSER(tuser16), .digest_done(done16),
    .fsm_state(fsm16)
  );

  keccak_digest_streamer #(.DATA_WIDTH(32), .ID_WIDTH(2), .USER_WIDTH(4)) dut32 (
    .ACLK(ACLK), .ARESET(ARESET), .state_in(st32), .state_valid(sv32),
    .state_ready(rdy32), .mode(mode32), .id_in(id32), .user_in(user32),
    .TDATA(tdata32), .TVALID(tvalid32), .TREADY(tready32), .TLAST(tlast32),
    .TKEEP(tkeep32), .TID(tid32), .TUSER(tuser32), .digest_done(done32),
    .fsm_state(fsm32)
  );

  // Scoreboard entries: {last, id, user, data}
  logic [22:0] exp_q16[$];
  logic [38:0] exp_q32[$];
  logic [15:0] obs16 [64];
  logic [31:0] obs32 [16];
  int beat_idx16 = 0, len16 = 0, done_cnt16 = 0, exp_done16 = 0;
  int beat_idx32 = 0, len32 = 0, done_cnt32 = 0;
  logic prev_done16 = 1'b0;
  int n_tab16 [4] = '{14, 16, 24, 32};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name, input logic [63:0] act);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: got %0h expected nothing at %0t", name, act, $time);
  endtask

  function automatic keccak_state_t build_state();
    keccak_state_t s;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        s[y][x] = tb_lanes[5*y + x];
    return s;
  endfunction

  function automatic logic [15:0] word16(input int k);
    logic [63:0] l;
    l = tb_lanes[k/4];
    return l[16*(k%4) +: 16];
  endfunction

  function automatic logic [31:0] word32(input int k);
    logic [63:0] l;
    l = tb_lanes[k/2];
    return l[32*(k%2) +: 32];
  endfunction

  // Monitors
  always @(negedge ACLK) begin
    if (ARESET) begin
      beat_idx16 = 0;
      prev_done16 = 1'b0;
    end else begin
      if (prev_done16) check("ready_after_done16", rdy16, 1'b1);
      prev_done16 = done16;
      check("done_pulse16", done16, tvalid16 && tready16 && tlast16);
      if (done16) done_cnt16++;
      if (tvalid16 && tready16) begin
        check("tkeep16", tkeep16, 2'b11);
        if (exp_q16.size() == 0) begin
          report_fail("unexpected_beat16", {tlast16, tid16, tuser16, tdata16});
        end else begin
          check("beat16", {tlast16, tid16, tuser16, tdata16}, exp_q16.pop_front());
        end
        if (beat_idx16 < 64) obs16[beat_idx16] = tdata16;
        beat_idx16++;
        if (tlast16) begin
          len16 = beat_idx16;
          beat_idx16 = 0;
        end
      end
    end
  end

  always @(negedge ACLK) begin
    if (ARESET) begin
      beat_idx32 = 0;
    end else begin
      if (done32) done_cnt32++;
      if (tvalid32) check("tkeep32", tkeep32, 4'hF);
      if (tvalid32 && tready32) begin
        if (exp_q32.size() == 0) begin
          report_fail("unexpected_beat32", {tlast32, tid32, tuser32, tdata32});
        end else begin
          check("beat32", {tlast32, tid32, tuser32, tdata32}, exp_q32.pop_front());
        end
        if (beat_idx32 < 16) obs32[beat_idx32] = tdata32;
        beat_idx32++;
        if (tlast32) begin
          len32 = beat_idx32;
          beat_idx32 = 0;
        end
      end
    end
  end

  // Drivers
  task automatic send16(input logic [1:0] m, input logic [1:0] id, input logic [3:0] user);
    int n;
    int guard;
    guard = 0;
    while (!rdy16 && guard < 200) begin
      @(posedge ACLK); #1;
      guard++;
    end
    if (!rdy16) report_fail("ready_timeout16", rdy16);
    st16 = build_state();
    mode16 = m; id16 = id; user16 = user; sv16 = 1'b1;
    n = n_tab16[m];
    for (int k = 0; k < n; k++) exp_q16.push_back({(k == n-1), id, user, word16(k)});
    exp_done16++;
    @(posedge ACLK); #1;
    sv16 = 1'b0;
    mode16 = ~m; id16 = ~id; user16 = ~user;
    check("first_beat_valid16", tvalid16, 1'b1);
  endtask

  task automatic wait_idle16();
    int guard;
    guard = 0;
    while (!(exp_q16.size() == 0 && rdy16) && guard < 400) begin
      @(posedge ACLK); #1;
      guard++;
    end
    if (exp_q16.size() != 0 || !rdy16) report_fail("idle_timeout16", exp_q16.size());
  endtask

  task automatic wait_beat16(input int idx);
    int guard;
    guard = 0;
    while (!(beat_idx16 == idx && tvalid16) && guard < 200) begin
      @(posedge ACLK); #1;
      guard++;
    end
    if (beat_idx16 != idx) report_fail("beat_wait_timeout16", beat_idx16);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [15:0] held_data;
    logic held_last;
    int guard;

    tb_lanes[0] = 64'h0123_4567_89AB_CDEF;
    tb_lanes[1] = 64'hFEDC_BA98_7654_3210;
    tb_lanes[2] = 64'h0F1E_2D3C_4B5A_6978;
    tb_lanes[3] = 64'h1111_2222_3333_4444;
    tb_lanes[4] = 64'hA5A5_5A5A_C3C3_3C3C;
    tb_lanes[5] = 64'h5555_6666_7777_8888;
    tb_lanes[6] = 64'h9999_AAAA_BBBB_CCCC;
    tb_lanes[7] = 64'h7777_8888_9999_AAAA;
    for (int l = 8; l < 25; l++) tb_lanes[l] = 64'hDEAD_0000_0000_0000 | 64'(l);
    st16 = '0;
    st32 = '0;

    // Reset state
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("rst_tvalid", tvalid16, 1'b0);
    check("rst_tlast", tlast16, 1'b0);
    check("rst_tdata", tdata16, 16'h0);
    check("rst_tid", tid16, 2'd0);
    check("rst_tuser", tuser16, 4'd0);
    check("rst_done", done16, 1'b0);
    check("rst_ready", rdy16, 1'b1);
    check("rst_ready32", rdy32, 1'b1);

    // Mode 0 basic
    send16(2'd0, 2'd1, 4'h5);
    wait_idle16();
    check("m0_beat0", obs16[0], 16'hCDEF);
    check("m0_beat1", obs16[1], 16'h89AB);
    check("m0_beat2", obs16[2], 16'h4567);
    check("m0_beat3", obs16[3], 16'h0123);
    check("m0_beat13", obs16[13], 16'h3333);
    check("m0_len", len16, 14);

    // Modes 3, 1, 2
    send16(2'd3, 2'd2, 4'h9);
    wait_idle16();
    check("m3_len", len16, 32);
    check("m3_beat31", obs16[31], 16'h7777);
    send16(2'd1, 2'd3, 4'hC);
    wait_idle16();
    check("m1_len", len16, 16);
    send16(2'd2, 2'd0, 4'h3);
    wait_idle16();
    check("m2_len", len16, 24);

    // Backpressure on beat 5
    send16(2'd0, 2'd2, 4'h7);
    wait_beat16(5);
    tready16 = 1'b0;
    held_data = tdata16;
    held_last = tlast16;
    check("stall_beat5", held_data, 16'h7654);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("stall_tvalid", tvalid16, 1'b1);
      check("stall_tdata", tdata16, held_data);
      check("stall_tlast", tlast16, held_last);
    end
    @(posedge ACLK); #1;
    tready16 = 1'b1;
    wait_idle16();
    check("stall_len", len16, 14);
    check("stall_beat6", obs16[6], 16'hBA98);

    // state_valid during SEND is ignored
    send16(2'd0, 2'd1, 4'h5);
    wait_beat16(3);
    st16 = ~build_state();
    mode16 = 2'd3; id16 = 2'd2; user16 = 4'hA; sv16 = 1'b1;
    check("send_not_ready", rdy16, 1'b0);
    @(posedge ACLK); #1;
    sv16 = 1'b0;
    wait_idle16();
    check("ignore_len", len16, 14);
    check("ignore_beat13", obs16[13], 16'h3333);
    send16(2'd2, 2'd3, 4'h2);
    wait_idle16();
    check("after_ignore_len", len16, 24);

    // Reset mid-burst on beat 7 of mode 1
    send16(2'd1, 2'd3, 4'h6);
    wait_beat16(7);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check("midrst_tvalid", tvalid16, 1'b0);
    check("midrst_tlast", tlast16, 1'b0);
    check("midrst_done", done16, 1'b0);
    ARESET = 1'b0;
    exp_q16.delete();
    exp_done16--;
    @(posedge ACLK); #1;
    check("midrst_ready", rdy16, 1'b1);
    tb_lanes[0] = 64'hCAFE_F00D_DEAD_BEEF;
    send16(2'd0, 2'd0, 4'h1);
    wait_idle16();
    check("midrst_beat0", obs16[0], 16'hBEEF);
    check("midrst_len", len16, 14);
    tb_lanes[0] = 64'h0123_4567_89AB_CDEF;

    // DATA_WIDTH=32, mode 0
    st32 = build_state();
    mode32 = 2'd0; id32 = 2'd2; user32 = 4'hB; sv32 = 1'b1;
    for (int k = 0; k < 7; k++) exp_q32.push_back({(k == 6), 2'd2, 4'hB, word32(k)});
    @(posedge ACLK); #1;
    sv32 = 1'b0;
    mode32 = 2'd3;
    check("first_beat_valid32", tvalid32, 1'b1);
    guard = 0;
    while (!(exp_q32.size() == 0 && rdy32) && guard < 100) begin
      @(posedge ACLK); #1;
      guard++;
    end
    if (exp_q32.size() != 0 || !rdy32) report_fail("idle_timeout32", exp_q32.size());
    check("w32_len", len32, 7);
    check("w32_beat0", obs32[0], 32'h89AB_CDEF);
    check("w32_beat6", obs32[6], 32'h3333_4444);
    check("w32_done_cnt", done_cnt32, 1);

    repeat (3) @(posedge ACLK);
    #1;
    check("done_cnt16", done_cnt16, exp_done16);
    check("exp_q16_empty", exp_q16.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/keccak_digest_streamer.md
Name: keccak_digest_streamer

Overview:
- Reverses the stream-to-state packing done ahead of the Keccak core.
- Takes one finished 5x5x64 Keccak state plus a digest-length mode.
- Serialises the leading digest bits into an AXI4-Stream master at DATA_WIDTH bits per beat and asserts TLAST on the final word.
- Sits between keccak_xor (Dout/Ready) and the output stream interface, and honours downstream TREADY backpressure.

Parameters:
- DATA_WIDTH, 16, stream word width; legal values 8, 16, 32 (elaboration error otherwise).
- ID_WIDTH, 2, width of TID pass-through.
- USER_WIDTH, 4, width of TUSER pass-through.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset, synchronous, active-high.
- state_in  in  [4:0][4:0][63:0]  Keccak state, indexed [y][x]; lane L = 5*y + x.
- state_valid  in  1  state_in/mode/id_in/user_in valid.
- state_ready  out  1  block can accept a new state.
- mode  in  2  digest length: 0=224, 1=256, 2=384, 3=512 bits.
- id_in  in  ID_WIDTH  TID to attach to the digest stream.
- user_in  in  USER_WIDTH  TUSER to attach.
- TDATA  out  DATA_WIDTH  digest word.
- TVALID  out  1  word valid.
- TREADY  in  1  downstream accepts.
- TLAST  out  1  final digest word.
- TKEEP  out  DATA_WIDTH/8  always all-ones.
- TID  out  ID_WIDTH  captured id_in.
- TUSER  out  USER_WIDTH  captured user_in.
- digest_done  out  1  one-cycle pulse on final handshake.

Behaviour:
- Synchronous active-high reset:
  - FSM enters IDLE; word counter 0; capture register 0.
  - TVALID=0, TLAST=0, TDATA=0, TID=0, TUSER=0, digest_done=0.
  - state_ready=1 from the first cycle after reset deasserts (state_ready is decoded from FSM==IDLE).
- FSM states:
  - IDLE:
    - state_ready=1, TVALID=0.
    - When state_valid=1, capture lanes 0..7 (512 bits), N = digest_bits/DATA_WIDTH, id_in and user_in, then go to SEND.
    - N is 14/16/24/32 at DATA_WIDTH=16; 28/32/48/64 at 8; 7/8/12/16 at 32.
  - SEND:
    - TVALID=1, state_ready=0.
    - TDATA = word cnt, where word k = lane[k / (64/DATA_WIDTH)] bits [DATA_WIDTH*(k mod (64/DATA_WIDTH)) +: DATA_WIDTH]. Lanes are little-endian, lower lane index first.
    - TLAST = (cnt == N-1).
    - On TVALID & TREADY: if not last, cnt <= cnt+1. If last, pulse digest_done, cnt <= 0, go to IDLE.
- Latency: the first beat is presented in the cycle after the state_valid capture edge. One-beat-per-cycle throughput while TREADY=1. One idle cycle between digests.
- AXI rules:
  - TVALID never depends on TREADY.
  - Once TVALID=1, TDATA/TLAST/TID/TUSER/TKEEP are held stable until the handshake.
  - TVALID does not drop before the final handshake except on reset.
- Ignored inputs:
  - state_valid during SEND is ignored; no capture and no state_ready.
  - mode, id_in and user_in changes during SEND have no effect; values are latched only at capture.
- Reset mid-burst: TVALID=0 and TLAST=0 at the next edge, partial digest discarded, no digest_done. The next capture restarts at word 0.
- TREADY held low indefinitely: the block stalls in SEND with outputs frozen. No timeout.
- Counter is 6 bits, sized for the maximum N=64 (DATA_WIDTH=8, mode 3). It never wraps past N-1.

Decomposition:
- Shared package sha_stream_pkg holds:
  - typedef keccak_state_t ([4:0][4:0][63:0]).
  - typedef lane_t (64 bits).
  - enum digest_mode_e (D224, D256, D384, D512).
  - function digest_words(mode, width) returning N.
- One sub-module, digest_word_sel: combinational selection of word k from the 512-bit capture register (lane index and bit offset).
- The FSM, counter and handshake stay in the top module.

Test Plan:
- Mode 0, DATA_WIDTH=16, lane0=64'h0123_4567_89AB_CDEF, lane3=64'h1111_2222_3333_4444, TREADY=1:
  - Beats 0..3 = CDEF, 89AB, 4567, 0123.
  - Exactly 14 beats; beat 13 = 3333 with TLAST=1.
  - digest_done pulses once; state_ready=1 the next cycle.
- Mode 3: 32 beats; beat 31 = lane7[63:48] with TLAST.
  - Modes 1 and 2 give TLAST on beats 15 and 23 respectively.
- Backpressure: TREADY=0 for 3 cycles while beat 5 is presented.
  - TDATA/TVALID/TLAST are unchanged across the stall; beat 6 appears only after TREADY=1.
  - Total beats remain 14 with no duplicates or drops.
- state_valid pulsed with a different state and mode=3 during SEND:
  - Ignored; the current digest completes unchanged with its original TID/TUSER.
  - A subsequent state_valid in IDLE starts the new digest.
- ARESET asserted on beat 7 of a mode-1 burst:
  - TVALID=0 and TLAST=0 the next cycle; no digest_done.
  - After release, a new state produces beat 0 = lane0[15:0].
- DATA_WIDTH=32, mode 0: 7 beats; beat 0 = 89AB_CDEF; TLAST on beat 6; TKEEP=4'hF throughout.
